// File: rtl/kt_ram_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kt_ram_writer_pkg
// Brief    : Shared constants, state encoding and word split helper for the
//            round-constant RAM writer.
// Revision : 1.0 - initial release
// ============================================================================
package kt_ram_writer_pkg;

    localparam int RAM_ADDR_WIDTH = 8;
    localparam int KT_BASE_ADDR   = 'h80;
    localparam int KT_WORD_COUNT  = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_DONE   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_VDRAIN = 3'd4
    } kt_state_e;

    typedef struct packed {
        logic [15:0] hi;
        logic [15:0] lo;
    } kt_word_t;

    function automatic kt_word_t kt_split(input logic [31:0] word);
        kt_word_t w;
        w.hi = word[31:16];
        w.lo = word[15:0];
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kt_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : kt_ram_writer
// Brief    : Streams WORD_COUNT 32-bit Kt words into the hi/lo RAM pair at
//            BASE_ADDR+i. Optional read-back check: KT_WRITER_VERIFY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module kt_ram_writer
    import kt_ram_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int BASE_ADDR  = KT_BASE_ADDR,
    parameter int WORD_COUNT = KT_WORD_COUNT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [15:0]           ram_wdata_hi,
    output logic [15:0]           ram_wdata_lo,
    output logic                  ram_we,
`ifdef KT_WRITER_VERIFY_EN
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [15:0]           ram_rdata_hi,
    input  logic [15:0]           ram_rdata_lo,
    output logic                  verify_error,
    output logic [ADDR_WIDTH-1:0] err_addr,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            words_written
);

    generate
        if ((BASE_ADDR + WORD_COUNT > (1 << ADDR_WIDTH)) || (WORD_COUNT < 1) ||
            (WORD_COUNT > 127)) begin : g_param_check
            $error("kt_ram_writer: BASE_ADDR+WORD_COUNT exceeds RAM depth or WORD_COUNT out of range");
        end
    endgenerate

    localparam logic [6:0]            c_last_idx = 7'(WORD_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] c_base     = ADDR_WIDTH'(BASE_ADDR);

    kt_state_e             r_state;
    logic                  r_we;
    logic                  r_busy;
    logic                  r_done;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [15:0]           r_hi;
    logic [15:0]           r_lo;
    logic [6:0]            r_count;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_waddr;
    kt_word_t              w_word;

`ifdef KT_WRITER_VERIFY_EN
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [6:0]            r_vidx;
    logic                  r_p1_v;
    logic                  r_p1_last;
    logic [31:0]           r_p1_data;
    logic                  r_p2_v;
    logic                  r_p2_last;
    logic [31:0]           r_p2_data;
    logic [ADDR_WIDTH-1:0] r_p2_addr;
    logic                  r_verr;
    logic [ADDR_WIDTH-1:0] r_eaddr;
    logic                  w_mismatch;

    assign w_ready    = (r_state == ST_WRITE) || (r_state == ST_VERIFY);
    assign w_mismatch = r_p2_v && ({ram_rdata_hi, ram_rdata_lo} != r_p2_data);
`else
    assign w_ready    = (r_state == ST_WRITE);
`endif

    assign w_accept = in_valid & w_ready;
    assign w_last   = (r_count == c_last_idx);
    assign w_waddr  = c_base + ADDR_WIDTH'(r_count);
    assign w_word   = kt_split(in_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_waddr <= c_base;
            r_hi    <= 16'd0;
            r_lo    <= 16'd0;
            r_count <= 7'd0;
`ifdef KT_WRITER_VERIFY_EN
            r_raddr   <= c_base;
            r_vidx    <= 7'd0;
            r_p1_v    <= 1'b0;
            r_p1_last <= 1'b0;
            r_p1_data <= 32'd0;
            r_p2_v    <= 1'b0;
            r_p2_last <= 1'b0;
            r_p2_data <= 32'd0;
            r_p2_addr <= c_base;
            r_verr    <= 1'b0;
            r_eaddr   <= '0;
`endif
        end else begin
            r_we <= 1'b0;
`ifdef KT_WRITER_VERIFY_EN
            r_p1_v    <= 1'b0;
            r_p2_v    <= r_p1_v;
            r_p2_last <= r_p1_last;
            r_p2_data <= r_p1_data;
            r_p2_addr <= r_raddr;
            // Only the first mismatching address is kept
            if (w_mismatch && !r_verr) begin
                r_verr  <= 1'b1;
                r_eaddr <= r_p2_addr;
            end
`endif
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_WRITE;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_count <= 7'd0;
`ifdef KT_WRITER_VERIFY_EN
                        r_verr  <= 1'b0;
                        r_eaddr <= '0;
`endif
                    end
                end
                ST_WRITE: begin
                    if (w_accept) begin
                        r_we    <= 1'b1;
                        r_waddr <= w_waddr;
                        r_hi    <= w_word.hi;
                        r_lo    <= w_word.lo;
                        r_count <= r_count + 7'd1;
                        if (w_last) begin
`ifdef KT_WRITER_VERIFY_EN
                            r_state <= ST_VERIFY;
                            r_vidx  <= 7'd0;
`else
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
`endif
                        end
                    end
                end
`ifdef KT_WRITER_VERIFY_EN
                ST_VERIFY: begin
                    // Source re-streams the table; each word is checked against the RAM read-back
                    if (w_accept) begin
                        r_raddr   <= c_base + ADDR_WIDTH'(r_vidx);
                        r_p1_v    <= 1'b1;
                        r_p1_last <= (r_vidx == c_last_idx);
                        r_p1_data <= in_data;
                        r_vidx    <= r_vidx + 7'd1;
                        if (r_vidx == c_last_idx) begin
                            r_state <= ST_VDRAIN;
                        end
                    end
                end
                ST_VDRAIN: begin
                    if (r_p2_v && r_p2_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready      = w_ready;
    assign ram_we        = r_we;
    assign ram_waddr     = r_waddr;
    assign ram_wdata_hi  = r_hi;
    assign ram_wdata_lo  = r_lo;
    assign busy          = r_busy;
    assign done          = r_done;
    assign words_written = r_count;
`ifdef KT_WRITER_VERIFY_EN
    assign ram_raddr     = r_raddr;
    assign verify_error  = r_verr;
    assign err_addr      = r_eaddr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kt_ram_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_kt_ram_writer
// Brief    : Randomized self-checking bench for kt_ram_writer against a
//            transaction-level model of the load protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kt_ram_writer;

    localparam int BASE = 'h80;
    localparam int N    = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic [7:0]  ram_waddr;
    logic [15:0] ram_wdata_hi;
    logic [15:0] ram_wdata_lo;
    logic        ram_we;
    logic        busy;
    logic        done;
    logic [6:0]  words_written;
`ifdef KT_WRITER_VERIFY_EN
    logic [7:0]  ram_raddr;
    logic [15:0] ram_rdata_hi;
    logic [15:0] ram_rdata_lo;
    logic        verify_error;
    logic [7:0]  err_addr;
    logic [31:0] ram_arr [256];
`endif

    int checks = 0;
    int errors = 0;

    // Model of the load: who is accepted, what gets written where
    bit          m_known = 0;
    bit          m_ready = 0;
    bit          m_busy  = 0;
    bit          m_done  = 0;
    bit          m_we    = 0;
    bit          m_pass  = 0;
    int          m_loaded = 0;
    int          m_vk    = 0;
    int          m_drain = 0;
    logic [7:0]  m_addr  = 8'(BASE);
    logic [31:0] m_data  = 32'd0;
    logic [31:0] exp_mem [256];
    logic [31:0] seen_mem [256];
    int          n_writes = 0;

    always #5 clk = ~clk;

    kt_ram_writer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .ram_waddr    (ram_waddr),
        .ram_wdata_hi (ram_wdata_hi),
        .ram_wdata_lo (ram_wdata_lo),
        .ram_we       (ram_we),
`ifdef KT_WRITER_VERIFY_EN
        .ram_raddr    (ram_raddr),
        .ram_rdata_hi (ram_rdata_hi),
        .ram_rdata_lo (ram_rdata_lo),
        .verify_error (verify_error),
        .err_addr     (err_addr),
`endif
        .busy         (busy),
        .done         (done),
        .words_written(words_written)
    );

`ifdef KT_WRITER_VERIFY_EN
    // RAM pair with 1-cycle read latency; address 0x85 reads back corrupted
    always @(posedge clk) begin
        if (ram_we) ram_arr[ram_waddr] <= {ram_wdata_hi, ram_wdata_lo};
        {ram_rdata_hi, ram_rdata_lo} <= ram_arr[ram_raddr] ^ ((ram_raddr == 8'h85) ? 32'h0000_0100 : 32'h0);
    end
`endif

    task automatic step(input bit v, input logic [31:0] d, input bit s, input bit r);
        bit acc;
        in_valid = v;
        in_data  = d;
        start    = s;
        reset    = r;
        #1;
        if (m_known) begin
            checks++;
            if (in_ready !== m_ready) begin
                errors++;
                $display("FAIL in_ready t=%0t got %b exp %b", $time, in_ready, m_ready);
            end
        end
        acc = m_ready && v;
        @(posedge clk);
        #1;
        m_we = 1'b0;
        if (r) begin
            m_known = 1; m_ready = 0; m_busy = 0; m_done = 0; m_loaded = 0;
            m_addr = 8'(BASE); m_data = 32'd0; m_pass = 0; m_vk = 0; m_drain = 0;
        end else begin
            if (m_drain > 0) begin
                m_drain--;
                if (m_drain == 0) begin m_busy = 0; m_done = 1; end
            end
            if (acc && !m_pass) begin
                m_we = 1'b1;
                m_addr = 8'(BASE + m_loaded);
                m_data = d;
                exp_mem[m_addr] = d;
                m_loaded++;
                if (m_loaded == N) begin
`ifdef KT_WRITER_VERIFY_EN
                    m_pass = 1; m_vk = 0;
`else
                    m_ready = 0; m_busy = 0; m_done = 1;
`endif
                end
            end else if (acc) begin
                m_vk++;
                if (m_vk == N) begin m_ready = 0; m_drain = 2; end
            end else if (s && !m_busy) begin
                m_ready = 1; m_busy = 1; m_done = 0; m_loaded = 0; m_pass = 0; m_vk = 0;
            end
        end
        if (ram_we === 1'b1) begin
            seen_mem[ram_waddr] = {ram_wdata_hi, ram_wdata_lo};
            n_writes++;
        end
        checks++;
        if (ram_we !== m_we) begin
            errors++;
            $display("FAIL ram_we t=%0t got %b exp %b", $time, ram_we, m_we);
        end
        checks++;
        if ({busy, done} !== {m_busy, m_done}) begin
            errors++;
            $display("FAIL busy_done t=%0t got %b%b exp %b%b", $time, busy, done, m_busy, m_done);
        end
        checks++;
        if (words_written !== 7'(m_loaded)) begin
            errors++;
            $display("FAIL words_written t=%0t got %0d exp %0d", $time, words_written, m_loaded);
        end
        if (m_we || r) begin
            checks++;
            if ({ram_waddr, ram_wdata_hi, ram_wdata_lo} !== {m_addr, m_data}) begin
                errors++;
                $display("FAIL write_word t=%0t got %h:%h%h exp %h:%h", $time,
                         ram_waddr, ram_wdata_hi, ram_wdata_lo, m_addr, m_data);
            end
        end
    endtask

    task automatic check_table(input string name, input int exp_writes);
        int bad = 0;
        for (int a = BASE; a < BASE + N; a++) begin
            if (seen_mem[a] !== exp_mem[a]) bad++;
        end
        checks++;
        if (bad != 0 || n_writes != exp_writes) begin
            errors++;
            $display("FAIL %s table bad_entries=%0d writes got %0d exp %0d", name, bad, n_writes, exp_writes);
        end
    endtask

    task automatic test_reset;
        step(0, 32'd0, 0, 1);
        step(1, $urandom, 1, 1);
        step(0, 32'd0, 0, 0);
    endtask

    task automatic test_continuous;
        n_writes = 0;
        step(0, 32'd0, 1, 0);
        for (int i = 0; i < N; i++) step(1, 32'(i) * 32'h0101_0101, 0, 0);
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0);
        check_table("continuous", N);
    endtask

    task automatic test_gaps;
        int k = 0;
        n_writes = 0;
        step(0, 32'd0, 1, 0);
        while (!m_done && k < 400) begin
            step((k % 4 == 0) || (k % 4 == 3), $urandom, 0, 0);
            k++;
        end
        check_table("gaps", N);
    endtask

    task automatic test_idle_valid;
        n_writes = 0;
        step(0, 32'd0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
        step(1, $urandom, 1, 0);
        for (int i = 0; i < N; i++) step(1, $urandom, 0, 0);
        for (int i = 0; i < 5; i++) step(1, $urandom, 0, 0);
        check_table("idle_valid", N);
    endtask

    task automatic test_start_during_load;
        n_writes = 0;
        step(0, 32'd0, 1, 0);
        for (int i = 0; i < N; i++) step(1, $urandom, (i == 10), 0);
        step(0, 32'd0, 0, 0);
        check_table("start_ignored", N);
    endtask

    task automatic test_reset_mid_load;
        n_writes = 0;
        step(0, 32'd0, 1, 0);
        for (int i = 0; i < 20; i++) step(1, $urandom, 0, 0);
        step(1, $urandom, 0, 1);
        step(0, 32'd0, 1, 0);
        for (int i = 0; i < N; i++) step(1, $urandom, 0, 0);
        check_table("reset_mid", 20 + N);
    endtask

    task automatic test_random;
        for (int load = 0; load < 3; load++) begin
            int k = 0;
            n_writes = 0;
            step(0, 32'd0, 1, 0);
            while (!m_done && k < 1000) begin
                step($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 9) == 0, 0);
                k++;
            end
            check_table("random", N);
        end
    endtask

`ifdef KT_WRITER_VERIFY_EN
    task automatic test_verify;
        logic [31:0] tbl [N];
        int k = 0;
        step(0, 32'd0, 0, 1);
        step(0, 32'd0, 1, 0);
        for (int i = 0; i < N; i++) begin
            tbl[i] = $urandom;
            step(1, tbl[i], 0, 0);
        end
        for (int i = 0; i < N; i++) step(1, tbl[i], 0, 0);
        while (done !== 1'b1 && k < 10) begin
            step(0, 32'd0, 0, 0);
            k++;
        end
        checks++;
        if ({done, verify_error, err_addr} !== {1'b1, 1'b1, 8'h85}) begin
            errors++;
            $display("FAIL verify got done=%b err=%b addr=%h exp 1 1 85", done, verify_error, err_addr);
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef KT_WRITER_VERIFY_EN
        test_verify;
`else
        test_continuous;
        test_gaps;
        test_idle_valid;
        test_start_during_load;
        test_reset_mid_load;
        test_random;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
